// File: rtl/fifo_reader_if.sv
// Signal bundle between the FIFO-read consumer and its neighbours:
// FIFO status/data/pop on one side, tick-paced sample output on the other.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  rd;
    logic                  tick;
    logic                  flush;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  underrun;
    logic [CNT_WIDTH-1:0]  underrun_cnt;
    logic [1:0]            level;

    // Environment side: drives FIFO status, tick and flush; observes outputs.
    modport master (
        output empty, r_data, tick, flush,
        input  rd, out_data, out_valid, underrun, underrun_cnt, level
    );

    // Reader side.
    modport slave (
        input  empty, r_data, tick, flush,
        output rd, out_data, out_valid, underrun, underrun_cnt, level
    );
endinterface

// File: rtl/fifo_reader.sv
// Read-side consumer: prefetches samples from the circular FIFO into a
// 2-entry buffer and releases one sample per tick, substituting zero and
// counting an underrun when the buffer is empty at tick time.
module fifo_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          clk,
    input  logic          reset,
    fifo_reader_if.slave  bus
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            level_q, level_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0]  underrun_cnt_q, underrun_cnt_d;
    logic                  pop_s;
    logic                  rd_s;

    // Pop/push decode; rd is held low in reset so nothing leaves the FIFO unseen.
    always_comb begin
        pop_s = bus.tick & (level_q != 2'd0);
        rd_s  = reset & ~bus.empty & ~bus.flush & ((level_q < 2'd2) | pop_s);
    end

    // Prefetch buffer next state: flush empties it, else push/pop combinations.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (bus.flush) begin
            level_d = 2'd0;
        end else begin
            case ({rd_s, pop_s})
                2'b10: begin
                    if (level_q == 2'd0) begin
                        head_d = bus.r_data;
                    end else begin
                        tail_d = bus.r_data;
                    end
                    level_d = level_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    level_d = level_q - 2'd1;
                end
                2'b11: begin
                    if (level_q == 2'd1) begin
                        head_d = bus.r_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = bus.r_data;
                    end
                end
                default: begin
                    level_d = level_q;
                end
            endcase
        end
    end

    // Output stage: on tick emit head (or zero + underrun); otherwise hold data.
    always_comb begin
        out_data_d     = out_data_q;
        out_valid_d    = 1'b0;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        if (bus.tick) begin
            out_valid_d = 1'b1;
            if (level_q != 2'd0) begin
                out_data_d = head_q;
            end else begin
                out_data_d = {DATA_WIDTH{1'b0}};
                underrun_d = 1'b1;
                if (underrun_cnt_q != {CNT_WIDTH{1'b1}}) begin
                    underrun_cnt_d = underrun_cnt_q + CNT_WIDTH'(1);
                end else begin
                    underrun_cnt_d = underrun_cnt_q;
                end
            end
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State registers; reset clears buffer contents and the underrun count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q         <= {DATA_WIDTH{1'b0}};
            tail_q         <= {DATA_WIDTH{1'b0}};
            level_q        <= 2'd0;
            out_data_q     <= {DATA_WIDTH{1'b0}};
            out_valid_q    <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            level_q        <= level_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign bus.rd           = rd_s;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.underrun     = underrun_q;
    assign bus.underrun_cnt = underrun_cnt_q;
    assign bus.level        = level_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a small FIFO model feeds the main instance,
// a second instance with a 2-bit counter checks saturation.
module tb_fifo_reader;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_WIDTH(24), .CNT_WIDTH(16)) bif();
    fifo_reader_if #(.DATA_WIDTH(24), .CNT_WIDTH(2))  sif();

    fifo_reader #(.DATA_WIDTH(24), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    fifo_reader #(.DATA_WIDTH(24), .CNT_WIDTH(2)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    // Simple source FIFO model for the main instance.
    logic [23:0] mem [0:63];
    logic [5:0]  wr_ptr = 6'd0;
    logic [5:0]  rd_ptr = 6'd0;

    assign bif.empty  = (rd_ptr == wr_ptr);
    assign bif.r_data = mem[rd_ptr];

    always @(posedge clk or negedge reset) begin
        if (!reset) rd_ptr <= wr_ptr;
        else if (bif.rd) rd_ptr <= rd_ptr + 6'd1;
    end

    // Saturation instance never sees data.
    assign sif.empty  = 1'b1;
    assign sif.r_data = 24'h000000;
    assign sif.flush  = 1'b0;

    task automatic push_fifo(input logic [23:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bif.tick = 1'b0;
        bif.flush = 1'b0;
        sif.tick = 1'b0;
        @(negedge clk);
        push_fifo(24'hABCDEF);
        #1;
        n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b expected 0", bif.rd); end
        n_vec++; if (bif.out_data !== 24'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", bif.out_data); end
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); end
        n_vec++; if (bif.underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", bif.underrun); end
        n_vec++; if (bif.underrun_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", bif.underrun_cnt); end
        n_vec++; if (bif.level !== 2'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", bif.level); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle_underrun;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bif.tick = 1'b1;
            #1;
            n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL idle_rd: got %b expected 0", bif.rd); end
            @(posedge clk); #1;
            n_vec++; if (bif.out_valid !== 1'b1) begin n_err++; $display("FAIL idle_valid: got %b expected 1", bif.out_valid); end
            n_vec++; if (bif.out_data !== 24'h0) begin n_err++; $display("FAIL idle_data: got %h expected 0", bif.out_data); end
            n_vec++; if (bif.underrun !== 1'b1) begin n_err++; $display("FAIL idle_underrun: got %b expected 1", bif.underrun); end
            n_vec++; if (bif.underrun_cnt !== 16'(k)) begin n_err++; $display("FAIL idle_cnt: got %0d expected %0d", bif.underrun_cnt, k); end
            @(negedge clk);
            bif.tick = 1'b0;
            #1;
            n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL idle_rd2: got %b expected 0", bif.rd); end
            @(posedge clk); #1;
            n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid_low: got %b expected 0", bif.out_valid); end
            n_vec++; if (bif.underrun !== 1'b0) begin n_err++; $display("FAIL idle_underrun_low: got %b expected 0", bif.underrun); end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_prefetch;
        int rd_count;
        rd_count = 0;
        @(negedge clk);
        push_fifo(24'h000011);
        push_fifo(24'h000022);
        push_fifo(24'h000033);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bif.rd === 1'b1) rd_count++;
            @(negedge clk);
        end
        #1;
        n_vec++; if (rd_count != 2) begin n_err++; $display("FAIL prefetch_rd_count: got %0d expected 2", rd_count); end
        n_vec++; if (bif.level !== 2'd2) begin n_err++; $display("FAIL prefetch_level: got %0d expected 2", bif.level); end
        n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL prefetch_rd_idle: got %b expected 0", bif.rd); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp_data [0:3];
        logic        exp_und  [0:3];
        logic        exp_rd   [0:3];
        exp_data[0] = 24'h000011; exp_und[0] = 1'b0; exp_rd[0] = 1'b1;
        exp_data[1] = 24'h000022; exp_und[1] = 1'b0; exp_rd[1] = 1'b0;
        exp_data[2] = 24'h000033; exp_und[2] = 1'b0; exp_rd[2] = 1'b0;
        exp_data[3] = 24'h000000; exp_und[3] = 1'b1; exp_rd[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif.tick = 1'b1;
            #1;
            n_vec++; if (bif.rd !== exp_rd[i]) begin n_err++; $display("FAIL b2b_rd[%0d]: got %b expected %b", i, bif.rd, exp_rd[i]); end
            @(posedge clk); #1;
            n_vec++; if (bif.out_data !== exp_data[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bif.out_data, exp_data[i]); end
            n_vec++; if (bif.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bif.out_valid); end
            n_vec++; if (bif.underrun !== exp_und[i]) begin n_err++; $display("FAIL b2b_underrun[%0d]: got %b expected %b", i, bif.underrun, exp_und[i]); end
        end
        @(negedge clk);
        bif.tick = 1'b0;
        #1;
        n_vec++; if (bif.level !== 2'd0) begin n_err++; $display("FAIL b2b_level: got %0d expected 0", bif.level); end
        n_vec++; if (bif.underrun_cnt !== 16'd4) begin n_err++; $display("FAIL b2b_cnt: got %0d expected 4", bif.underrun_cnt); end
        @(posedge clk); #1;
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_low: got %b expected 0", bif.out_valid); end
        n_vec++; if (bif.out_data !== 24'h0) begin n_err++; $display("FAIL b2b_hold: got %h expected 0", bif.out_data); end
    endtask

    task automatic test_push_underrun;
        @(negedge clk);
        push_fifo(24'h000044);
        bif.tick = 1'b1;
        #1;
        n_vec++; if (bif.rd !== 1'b1) begin n_err++; $display("FAIL pu_rd: got %b expected 1", bif.rd); end
        @(posedge clk); #1;
        n_vec++; if (bif.out_data !== 24'h0) begin n_err++; $display("FAIL pu_data: got %h expected 0", bif.out_data); end
        n_vec++; if (bif.underrun !== 1'b1) begin n_err++; $display("FAIL pu_underrun: got %b expected 1", bif.underrun); end
        n_vec++; if (bif.underrun_cnt !== 16'd5) begin n_err++; $display("FAIL pu_cnt: got %0d expected 5", bif.underrun_cnt); end
        n_vec++; if (bif.level !== 2'd1) begin n_err++; $display("FAIL pu_level: got %0d expected 1", bif.level); end
        @(negedge clk);
        bif.tick = 1'b0;
        #1;
        n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL pu_rd_empty: got %b expected 0", bif.rd); end
        @(negedge clk);
        bif.tick = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bif.out_data !== 24'h000044) begin n_err++; $display("FAIL pu_next_data: got %h expected 000044", bif.out_data); end
        n_vec++; if (bif.underrun !== 1'b0) begin n_err++; $display("FAIL pu_next_underrun: got %b expected 0", bif.underrun); end
        n_vec++; if (bif.level !== 2'd0) begin n_err++; $display("FAIL pu_next_level: got %0d expected 0", bif.level); end
        @(negedge clk);
        bif.tick = 1'b0;
    endtask

    task automatic test_flush;
        push_fifo(24'h000055);
        push_fifo(24'h000066);
        push_fifo(24'h000077);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (bif.level !== 2'd2) begin n_err++; $display("FAIL flush_pre_level: got %0d expected 2", bif.level); end
        bif.flush = 1'b1;
        bif.tick = 1'b1;
        #1;
        n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL flush_rd: got %b expected 0", bif.rd); end
        @(posedge clk); #1;
        n_vec++; if (bif.out_data !== 24'h000055) begin n_err++; $display("FAIL flush_data: got %h expected 000055", bif.out_data); end
        n_vec++; if (bif.underrun !== 1'b0) begin n_err++; $display("FAIL flush_underrun: got %b expected 0", bif.underrun); end
        n_vec++; if (bif.level !== 2'd0) begin n_err++; $display("FAIL flush_level: got %0d expected 0", bif.level); end
        n_vec++; if (bif.underrun_cnt !== 16'd5) begin n_err++; $display("FAIL flush_cnt: got %0d expected 5", bif.underrun_cnt); end
        @(negedge clk);
        bif.flush = 1'b0;
        bif.tick = 1'b0;
        #1;
        n_vec++; if (bif.rd !== 1'b1) begin n_err++; $display("FAIL flush_refill_rd: got %b expected 1", bif.rd); end
        @(posedge clk); #1;
        n_vec++; if (bif.level !== 2'd1) begin n_err++; $display("FAIL flush_refill_level: got %0d expected 1", bif.level); end
        @(negedge clk);
        bif.tick = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bif.out_data !== 24'h000077) begin n_err++; $display("FAIL flush_next_data: got %h expected 000077", bif.out_data); end
        @(negedge clk);
        bif.tick = 1'b0;
    endtask

    task automatic test_saturate;
        logic [1:0] exp_cnt;
        for (int i = 1; i <= 5; i++) begin
            exp_cnt = (i > 3) ? 2'd3 : 2'(i);
            @(negedge clk);
            sif.tick = 1'b1;
            @(posedge clk); #1;
            n_vec++; if (sif.underrun !== 1'b1) begin n_err++; $display("FAIL sat_underrun[%0d]: got %b expected 1", i, sif.underrun); end
            n_vec++; if (sif.underrun_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, sif.underrun_cnt, exp_cnt); end
            @(negedge clk);
            sif.tick = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        push_fifo(24'h000088);
        push_fifo(24'h000099);
        @(negedge clk);
        @(negedge clk);
        bif.tick = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bif.out_data !== 24'h000088) begin n_err++; $display("FAIL mid_pre_data: got %h expected 000088", bif.out_data); end
        #1;
        reset = 1'b0;
        #1;
        n_vec++; if (bif.out_data !== 24'h0) begin n_err++; $display("FAIL mid_data: got %h expected 0", bif.out_data); end
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b expected 0", bif.out_valid); end
        n_vec++; if (bif.underrun_cnt !== 16'd0) begin n_err++; $display("FAIL mid_cnt: got %0d expected 0", bif.underrun_cnt); end
        n_vec++; if (bif.level !== 2'd0) begin n_err++; $display("FAIL mid_level: got %0d expected 0", bif.level); end
        n_vec++; if (bif.rd !== 1'b0) begin n_err++; $display("FAIL mid_rd: got %b expected 0", bif.rd); end
        n_vec++; if (sif.underrun_cnt !== 2'd0) begin n_err++; $display("FAIL mid_sat_cnt: got %0d expected 0", sif.underrun_cnt); end
        @(negedge clk);
        bif.tick = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_prefetch();
        test_back_to_back();
        test_push_underrun();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
